// File: rtl/ioexp_host.sv
// Initiator for the 8243-style expander link: turns nibble commands into P2/PROG
// waveforms, with all timing counted in clk cycles.
module ioexp_host #(
    parameter int T_SETUP     = 2,
    parameter int T_PROG      = 4,
    parameter int T_HOLD      = 2,
    parameter int T_GAP       = 2,
    parameter int INIT_PULSES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_port,
    input  logic [3:0] cmd_data,
    output logic       done,
    output logic [3:0] rsp_data,
    output logic [3:0] p2o,
    output logic       p2_oe,
    input  logic [3:0] p2i,
    output logic       prog_n
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SETUP, S_PROG, S_HOLD, S_GAP
    } state_t;

    localparam logic [1:0] OP_RD = 2'b00;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] init_cnt;
    logic [1:0] op_q;
    logic [3:0] data_q;
    logic       is_init;
    logic [3:0] p2i_s1, p2i_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p2i_s1 <= 4'h0;
            p2i_s2 <= 4'h0;
        end else begin
            p2i_s1 <= p2i;
            p2i_s2 <= p2i_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT;
            cnt       <= 8'd0;
            init_cnt  <= 8'd0;
            op_q      <= 2'b00;
            data_q    <= 4'h0;
            is_init   <= 1'b0;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            rsp_data  <= 4'h0;
            p2o       <= 4'h0;
            p2_oe     <= 1'b0;
            prog_n    <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                // Dummy port-6 reads give the responder the PROG edges it needs to leave reset.
                S_INIT: begin
                    if (INIT_PULSES == 0) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        op_q    <= OP_RD;
                        data_q  <= 4'h0;
                        is_init <= 1'b1;
                        p2o     <= {OP_RD, 2'b10};
                        p2_oe   <= 1'b1;
                        cnt     <= 8'(T_SETUP - 1);
                        state   <= S_SETUP;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        data_q    <= cmd_data;
                        is_init   <= 1'b0;
                        cmd_ready <= 1'b0;
                        p2o       <= {cmd_op, cmd_port};
                        p2_oe     <= 1'b1;
                        cnt       <= 8'(T_SETUP - 1);
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == 8'd0) begin
                        prog_n <= 1'b0;
                        // Release the bus on the same edge PROG falls so the responder can drive it.
                        if (op_q == OP_RD) begin
                            p2_oe <= 1'b0;
                            p2o   <= 4'h0;
                        end else begin
                            p2o <= data_q;
                        end
                        cnt   <= 8'(T_PROG - 1);
                        state <= S_PROG;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_PROG: begin
                    if (cnt == 8'd0) begin
                        prog_n <= 1'b1;
                        done   <= ~is_init;
                        if (op_q == OP_RD && !is_init)
                            rsp_data <= p2i_s2;
                        cnt   <= 8'(T_HOLD - 1);
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 8'd0) begin
                        p2_oe <= 1'b0;
                        p2o   <= 4'h0;
                        cnt   <= 8'(T_GAP - 1);
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 8'd0) begin
                        if (is_init)
                            init_cnt <= init_cnt + 8'd1;
                        if (is_init && (init_cnt + 8'd1 < 8'(INIT_PULSES))) begin
                            state <= S_INIT;
                        end else begin
                            state     <= S_IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ioexp_host.sv
// Directed bench for ioexp_host: default-timing instance plus a short-timing instance.
module tb_ioexp_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [1:0] cmd_port = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic       cmd_ready, done, p2_oe, prog_n;
    logic [3:0] rsp_data, p2o, p2i;
    logic [3:0] resp_val = 4'h0;

    logic       f_valid = 1'b0;
    logic [1:0] f_op = 2'b00;
    logic [1:0] f_port = 2'b00;
    logic       f_ready, f_done, f_oe, f_prog_n;
    logic [3:0] f_rsp, f_p2o, f_p2i;

    int total = 0;
    int bad   = 0;

    int   falls = 0, dones = 0, oe_low = 0;
    logic prev_pn = 1'b1;
    logic [3:0] last_setup = 4'h0;

    always #5 clk = ~clk;

    // Responders drive P2 only while PROG is low.
    assign p2i   = !prog_n   ? resp_val : 4'h0;
    assign f_p2i = !f_prog_n ? 4'h5     : 4'h0;

    ioexp_host u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_port(cmd_port), .cmd_data(cmd_data), .done(done),
        .rsp_data(rsp_data), .p2o(p2o), .p2_oe(p2_oe), .p2i(p2i), .prog_n(prog_n)
    );

    ioexp_host #(.T_SETUP(1), .T_PROG(3), .T_HOLD(1), .T_GAP(1), .INIT_PULSES(2)) u_fast (
        .clk(clk), .rst(rst), .cmd_valid(f_valid), .cmd_ready(f_ready),
        .cmd_op(f_op), .cmd_port(f_port), .cmd_data(4'h0), .done(f_done),
        .rsp_data(f_rsp), .p2o(f_p2o), .p2_oe(f_oe), .p2i(f_p2i), .prog_n(f_prog_n)
    );

    always @(negedge clk) begin
        if (prev_pn && !prog_n) falls = falls + 1;
        if (done) dones = dones + 1;
        if (p2_oe && !prog_n) oe_low = oe_low + 1;
        if (p2_oe && prog_n) last_setup = p2o;
        prev_pn = prog_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        falls = 0; dones = 0; oe_low = 0; last_setup = 4'h0;
    endtask

    task automatic wait_ready(input string tag);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        check(tag, 32'(cmd_ready), 32'd1);
    endtask

    // {ready, done, prog_n, oe, p2o} at cycle k after accept (defaults 2/4/2/2)
    function automatic logic [7:0] exp_sig(int k, logic [1:0] op, logic [1:0] port, logic [3:0] d);
        logic       rd;
        logic [3:0] pd;
        rd = (op == 2'b00);
        pd = rd ? 4'h0 : d;
        if (k <= 2)      return {1'b0, 1'b0, 1'b1, 1'b1, op, port};
        else if (k <= 6) return {1'b0, 1'b0, 1'b0, ~rd, pd};
        else if (k == 7) return {1'b0, 1'b1, 1'b1, ~rd, pd};
        else if (k == 8) return {1'b0, 1'b0, 1'b1, ~rd, pd};
        else if (k <= 10) return 8'b0010_0000;
        else             return 8'b1010_0000;
    endfunction

    // Called just after a negedge with cmd_ready=1; returns at cycle 11 (ready again).
    task automatic run_txn(input string tag, input logic [1:0] op, input logic [1:0] port,
                           input logic [3:0] d, input logic drop, input logic [3:0] exp_rsp);
        cmd_op = op; cmd_port = port; cmd_data = d; cmd_valid = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1 && drop) cmd_valid = 1'b0;
            check($sformatf("%s_k%0d", tag, k), 32'({cmd_ready, done, prog_n, p2_oe, p2o}),
                  32'(exp_sig(k, op, port, d)));
            if (k == 7 && op == 2'b00)
                check({tag, "_rsp"}, 32'(rsp_data), 32'(exp_rsp));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", 32'({cmd_ready, done, prog_n, p2_oe, p2o, rsp_data}),
              32'({1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0}));
        clr_mon();
        rst = 1'b0;
        wait_ready("init_ready");
        check("init_falls", 32'(falls), 32'd2);
        check("init_done", 32'(dones), 32'd0);
        check("init_setup", 32'(last_setup), 32'h2);
        check("init_oe_low", 32'(oe_low), 32'd0);
        check("init_rsp", 32'(rsp_data), 32'h0);

        run_txn("wr_p4", 2'b01, 2'b00, 4'hA, 1'b1, 4'h0);

        resp_val = 4'h9;
        run_txn("rd_p6", 2'b00, 2'b10, 4'h0, 1'b1, 4'h9);
        check("rd_hold", 32'(rsp_data), 32'h9);

        run_txn("or_p7", 2'b10, 2'b11, 4'h4, 1'b0, 4'h0);
        run_txn("and_p7", 2'b11, 2'b11, 4'hB, 1'b1, 4'h0);

        // Reset during the second PROG-low cycle of a write
        cmd_op = 2'b01; cmd_port = 2'b01; cmd_data = 4'h3; cmd_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
        end
        check("abort_prog_lo", 32'({prog_n, p2_oe}), 32'({1'b0, 1'b1}));
        clr_mon();
        rst = 1'b1;
        #1;
        check("abort_out", 32'({cmd_ready, done, prog_n, p2_oe, p2o}),
              32'({1'b0, 1'b0, 1'b1, 1'b0, 4'h0}));
        @(negedge clk);
        rst = 1'b0;
        wait_ready("reinit_ready");
        check("reinit_falls", 32'(falls), 32'd2);
        check("reinit_done", 32'(dones), 32'd0);

        // Short-timing instance: read of 0x5, 7-cycle latency
        for (int n = 0; n < 300; n++) begin
            if (f_ready) break;
            @(negedge clk);
        end
        check("fast_ready", 32'(f_ready), 32'd1);
        f_op = 2'b00; f_port = 2'b10; f_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) f_valid = 1'b0;
            if (k == 2) check("fast_prog_oe", 32'({f_prog_n, f_oe}), 32'({1'b0, 1'b0}));
            if (k == 5) check("fast_done", 32'({f_done, f_rsp}), 32'({1'b1, 4'h5}));
            if (k == 6) check("fast_busy", 32'({f_ready, f_done}), 32'd0);
            if (k == 7) check("fast_lat", 32'(f_ready), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
